// File: rtl/mips_cpu.sv
// Multi-cycle 32-bit MIPS core: PC, IM, RF, ALU, DM and a FETCH/DECODE/EXE/MEM/WB controller.
// Optional DEBUG_TRACE_EN prints every GPR write and store; logic is unchanged either way.

module mips_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] npc,
  output logic [31:0] pc
);
  logic [31:0] PC;

  always_ff @(posedge clk or posedge rst)
    if (rst)     PC <= RESET_PC;
    else if (we) PC <= npc;

  assign pc = PC;
endmodule

module mips_im #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  // Preloaded externally; never written or cleared by the core.
  logic [31:0] imem [0:DEPTH-1];

  assign rdata = imem[addr];
endmodule

module mips_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] gpr [0:31];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (we && wa != 5'd0) begin
      gpr[wa] <= wd;
    end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : gpr[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : gpr[ra2];
endmodule

module mips_dm #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] dmem [0:DEPTH-1];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (we) begin
      dmem[addr] <= wdata;
    end

  assign rdata = dmem[addr];
endmodule

module mips_cpu #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0]  state;
  logic [31:0] ir, a, b, aluout, mdr;
  logic [31:0] pc, pc_nxt, im_rd, rf_rd1, rf_rd2, dm_rd, rf_wd, alu_res, imm_ext, srcb;
  logic        pc_we, rf_we, dm_we;
  logic [4:0]  rf_wa, sh;

  wire [31:0] instr;
  assign instr = ir;

  wire [5:0]  op     = ir[31:26];
  wire [4:0]  rs     = ir[25:21];
  wire [4:0]  rt     = ir[20:16];
  wire [4:0]  rd     = ir[15:11];
  wire [4:0]  shamt  = ir[10:6];
  wire [5:0]  funct  = ir[5:0];
  wire [15:0] imm16  = ir[15:0];
  wire [25:0] imm26  = ir[25:0];

  logic is_r, is_ralu, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_ialu, is_zext, valid;

  always_comb begin
    is_r    = (op == 6'b000000);
    is_ralu = 1'b0;
    case (funct)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b101010, 6'b101011: is_ralu = is_r;
      default: is_ralu = 1'b0;
    endcase
    is_jr   = is_r && (funct == 6'b001000);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);
    is_beq  = (op == 6'b000100);
    is_bne  = (op == 6'b000101);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_ialu = (op[5:3] == 3'b001);
    is_zext = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
    valid   = is_ralu || is_jr || is_j || is_jal || is_beq || is_bne ||
              is_lw || is_sw || is_ialu;
  end

  always_comb begin
    imm_ext = is_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
    srcb    = is_r ? b : imm_ext;
    sh      = funct[2] ? a[4:0] : shamt;
    alu_res = '0;
    if (is_r) begin
      case (funct)
        6'b000000, 6'b000100: alu_res = b << sh;
        6'b000010, 6'b000110: alu_res = b >> sh;
        6'b000011, 6'b000111: alu_res = $unsigned($signed(b) >>> sh);
        6'b100000, 6'b100001: alu_res = a + b;
        6'b100010, 6'b100011: alu_res = a - b;
        6'b100100:            alu_res = a & b;
        6'b100101:            alu_res = a | b;
        6'b100110:            alu_res = a ^ b;
        6'b100111:            alu_res = ~(a | b);
        6'b101010:            alu_res = {31'b0, $signed(a) < $signed(b)};
        6'b101011:            alu_res = {31'b0, a < b};
        default:              alu_res = '0;
      endcase
    end else begin
      case (op)
        6'b001010: alu_res = {31'b0, $signed(a) < $signed(srcb)};
        6'b001011: alu_res = {31'b0, a < srcb};
        6'b001100: alu_res = a & srcb;
        6'b001101: alu_res = a | srcb;
        6'b001110: alu_res = a ^ srcb;
        6'b001111: alu_res = {imm16, 16'h0};
        default:   alu_res = a + srcb;   // addi/addiu and lw/sw address
      endcase
    end
  end

  // PC is already PC+4 once DECODE starts, so branch/jump targets build on it.
  always_comb begin
    pc_we  = 1'b0;
    pc_nxt = pc + 32'd4;
    case (state)
      S_FETCH:  pc_we = 1'b1;
      S_DECODE: if (is_j || is_jal) begin
        pc_we  = 1'b1;
        pc_nxt = {pc[31:28], imm26, 2'b00};
      end
      S_EXE: begin
        if ((is_beq && a == b) || (is_bne && a != b)) begin
          pc_we  = 1'b1;
          pc_nxt = pc + {{14{imm16[15]}}, imm16, 2'b00};
        end else if (is_jr) begin
          pc_we  = 1'b1;
          pc_nxt = a;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wa = rd;
    rf_wd = aluout;
    if (state == S_DECODE && is_jal) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = pc;
    end else if (state == S_WB) begin
      rf_we = 1'b1;
      rf_wa = is_r ? rd : rt;
      rf_wd = is_lw ? mdr : aluout;
    end
  end

  assign dm_we = (state == S_MEM) && is_sw;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_FETCH;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= im_rd;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a     <= rf_rd1;
          b     <= rf_rd2;
          state <= (!valid || is_j || is_jal) ? S_FETCH : S_EXE;
        end
        S_EXE: begin
          aluout <= alu_res;
          if (is_beq || is_bne || is_jr) state <= S_FETCH;
          else if (is_lw || is_sw)       state <= S_MEM;
          else                           state <= S_WB;
        end
        S_MEM: begin
          mdr   <= dm_rd;
          state <= is_lw ? S_WB : S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end

  mips_pc #(.RESET_PC(RESET_PC)) U_PC (
    .clk(clk), .rst(rst), .we(pc_we), .npc(pc_nxt), .pc(pc)
  );

  mips_im #(.DEPTH(IMEM_DEPTH), .AW(IAW)) U_IM (
    .addr(pc[IAW+1:2]), .rdata(im_rd)
  );

  mips_rf U_RF (
    .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rf_rd1), .rd2(rf_rd2),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd)
  );

  mips_dm #(.DEPTH(DMEM_DEPTH), .AW(DAW)) U_DM (
    .clk(clk), .rst(rst), .we(dm_we), .addr(aluout[DAW+1:2]), .wdata(b), .rdata(dm_rd)
  );

`ifdef DEBUG_TRACE_EN
  // Every GPR write and every store happens with PC one word past its instruction.
  always @(posedge clk) begin
    if (!rst && rf_we && rf_wa != 5'd0)
      $display("PC=%08X R%0d<=%08X", pc - 32'd4, rf_wa, rf_wd);
    if (!rst && dm_we)
      $display("PC=%08X M[%08X]<=%08X", pc - 32'd4, aluout, b);
  end
`endif
endmodule

// File: tb/tb_mips_cpu.sv
// Directed programs for mips_cpu with hand-computed register, memory and PC expectations.
module tb_mips_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mips_cpu dut (.clk(clk), .rst(rst));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 10 ns past the last one.
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #10;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.U_IM.imem[i] = 32'h0;
  endtask

  initial begin
    // Program 1: ALU, lui/ori, memory, compares, shifts, $0 write.
    clear_imem();
    dut.U_IM.imem[0] = 32'h3401_1234; // ori   $1,$0,0x1234
    dut.U_IM.imem[1] = 32'h3C02_ABCD; // lui   $2,0xABCD
    dut.U_IM.imem[2] = 32'h0022_1821; // addu  $3,$1,$2
    dut.U_IM.imem[3] = 32'hAC03_0008; // sw    $3,8($0)
    dut.U_IM.imem[4] = 32'h8C04_0008; // lw    $4,8($0)
    dut.U_IM.imem[5] = 32'h2405_FFFF; // addiu $5,$0,-1
    dut.U_IM.imem[6] = 32'h00A0_302A; // slt   $6,$5,$0
    dut.U_IM.imem[7] = 32'h00A0_382B; // sltu  $7,$5,$0
    dut.U_IM.imem[8] = 32'h0005_4103; // sra   $8,$5,4
    dut.U_IM.imem[9] = 32'h2400_0005; // addiu $0,$0,5

    #5  rst = 1'b1;
    #5;
    chk("rst_pc", dut.U_PC.PC, 32'h0000_3000);
    chk("rst_ir", dut.instr, 32'h0);
    chk("rst_gpr3", dut.U_RF.gpr[3], 32'h0);
    #15 rst = 1'b0;

    clks(1);
    chk("fetch_ir", dut.instr, 32'h3401_1234);
    chk("fetch_pc", dut.U_PC.PC, 32'h0000_3004);
    clks(10);
    chk("addu_not_yet", dut.U_RF.gpr[3], 32'h0);
    clks(1);
    chk("addu_gpr3", dut.U_RF.gpr[3], 32'hABCD_1234);
    chk("ori_gpr1", dut.U_RF.gpr[1], 32'h0000_1234);
    chk("lui_gpr2", dut.U_RF.gpr[2], 32'hABCD_0000);
    clks(4);
    chk("sw_dmem2", dut.U_DM.dmem[2], 32'hABCD_1234);
    clks(4);
    chk("lw_not_yet", dut.U_RF.gpr[4], 32'h0);
    clks(1);
    chk("lw_gpr4", dut.U_RF.gpr[4], 32'hABCD_1234);
    clks(20);
    chk("addiu_gpr5", dut.U_RF.gpr[5], 32'hFFFF_FFFF);
    chk("slt_gpr6", dut.U_RF.gpr[6], 32'h1);
    chk("sltu_gpr7", dut.U_RF.gpr[7], 32'h0);
    chk("sra_gpr8", dut.U_RF.gpr[8], 32'hFFFF_FFFF);
    chk("gpr0_zero", dut.U_RF.gpr[0], 32'h0);
    chk("p1_end_pc", dut.U_PC.PC, 32'h0000_3028);

    // Program 2: control flow and undefined opcode.
    rst = 1'b1;
    #20;
    clear_imem();
    dut.U_IM.imem[0]    = 32'h1000_0002; // 3000 beq $0,$0,+2
    dut.U_IM.imem[1]    = 32'h2409_0001; // 3004 addiu $9,$0,1 (skipped)
    dut.U_IM.imem[2]    = 32'h2409_0001; // 3008 addiu $9,$0,1 (skipped)
    dut.U_IM.imem[3]    = 32'h1400_0002; // 300C bne $0,$0,+2
    dut.U_IM.imem[4]    = 32'h0C00_0C40; // 3010 jal 0x3100
    dut.U_IM.imem[5]    = 32'hFC00_0000; // 3014 undefined
    dut.U_IM.imem[6]    = 32'h0800_0C08; // 3018 j 0x3020
    dut.U_IM.imem[10'h40] = 32'h03E0_0008; // 3100 jr $31
    rst = 1'b0;

    clks(3);
    chk("beq_pc", dut.U_PC.PC, 32'h0000_300C);
    clks(3);
    chk("bne_pc", dut.U_PC.PC, 32'h0000_3010);
    clks(2);
    chk("jal_pc", dut.U_PC.PC, 32'h0000_3100);
    chk("jal_gpr31", dut.U_RF.gpr[31], 32'h0000_3014);
    clks(3);
    chk("jr_pc", dut.U_PC.PC, 32'h0000_3014);
    clks(2);
    chk("nop_pc", dut.U_PC.PC, 32'h0000_3018);
    clks(1);
    chk("after_nop_ir", dut.instr, 32'h0800_0C08);
    clks(1);
    chk("j_pc", dut.U_PC.PC, 32'h0000_3020);
    chk("skip_gpr9", dut.U_RF.gpr[9], 32'h0);

    // Program 3: reset asserted while lw sits in MEM.
    rst = 1'b1;
    #20;
    clear_imem();
    dut.U_IM.imem[0] = 32'h3401_0055; // ori $1,$0,0x55
    dut.U_IM.imem[1] = 32'hAC01_0000; // sw  $1,0($0)
    dut.U_IM.imem[2] = 32'h8C04_0000; // lw  $4,0($0)
    rst = 1'b0;

    clks(8);
    chk("p3_sw_dmem0", dut.U_DM.dmem[0], 32'h0000_0055);
    clks(3);
    rst = 1'b1;
    #1;
    chk("midrst_pc", dut.U_PC.PC, 32'h0000_3000);
    clks(2);
    chk("midrst_gpr4", dut.U_RF.gpr[4], 32'h0);
    chk("midrst_ir", dut.instr, 32'h0);
    chk("midrst_dmem0", dut.U_DM.dmem[0], 32'h0);
    rst = 1'b0;
    clks(4);
    chk("restart_gpr1", dut.U_RF.gpr[1], 32'h0000_0055);
    chk("restart_pc", dut.U_PC.PC, 32'h0000_3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
